// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: session states
// and the framing constants of the host byte stream.
package imem_boot_loader_pkg;

  // Session sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  // Word-count header length and bytes per instruction word
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words. The first byte of a word
// ends up in bits [7:0] and the fourth in [31:24]. A one-cycle word_valid
// pulse follows the fourth byte, with the complete word on o_word.
module word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_last_byte
);

  localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_count;
  logic [31:0] r_shift;
  logic        r_valid;

  // Shift bytes in from the top so the first byte lands in the low lane
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_count <= '0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_shift <= {i_byte, r_shift[31:8]};
        r_count <= r_count + 2'd1;
        if (r_count == LAST_SLOT) begin
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_shift;
  assign o_word_valid = r_valid;
  assign o_last_byte  = (r_count == LAST_SLOT);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, receives a word count and program
// bytes from the host, writes them to consecutive instruction-memory words,
// then releases the core one cycle after the final write.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_core_rst_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_words_loaded
);

  localparam int         LEN_W     = 8 * LEN_BYTES;
  localparam logic [16:0] MAX_LIMIT = 17'(MAX_WORDS);

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic                  r_core_rst_n;

  logic                  w_accept;
  logic                  w_in_session;
  logic                  w_word_done;
  logic                  w_last_word;
  logic                  w_last_byte;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic [LEN_W-1:0]      w_len_full;
  logic                  w_asm_clear;
  logic                  w_asm_valid;

  assign w_in_session = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_DATA);
  assign w_accept     = i_rx_valid && w_in_session;
  assign w_len_full   = {i_rx_data, r_len[7:0]};
  assign w_asm_clear  = (r_state == ST_LEN_HI) && w_accept;
  assign w_asm_valid  = (r_state == ST_DATA) && w_accept;
  assign w_word_done  = w_asm_valid && w_last_byte;
  assign w_last_word  = (17'(r_words_loaded) + 17'd1) == 17'(r_len);

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte       (i_rx_data),
    .i_byte_valid (w_asm_valid),
    .i_clear      (w_asm_clear),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_last_byte  (w_last_byte)
  );

  // Session sequencer with word counting and delayed core reset release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_words_loaded <= '0;
      r_imem_addr    <= '0;
      r_core_rst_n   <= 1'b0;
    end else begin
      r_core_rst_n <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_LEN_LO;
            r_words_loaded <= '0;
          end
        end
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= i_rx_data;
            r_state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (w_accept) begin
            r_len          <= w_len_full;
            r_words_loaded <= '0;
            if (w_len_full == '0) begin
              r_state <= ST_DONE;
            end else if ({1'b0, w_len_full} > MAX_LIMIT) begin
              r_state <= ST_ERR;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_done) begin
            r_imem_addr    <= r_words_loaded[ADDR_WIDTH-1:0];
            r_words_loaded <= r_words_loaded + 1'b1;
            if (w_last_word) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_state        <= ST_LEN_LO;
            r_words_loaded <= '0;
          end else begin
            r_core_rst_n <= 1'b1;
          end
        end
        ST_ERR: begin
          if (i_start) begin
            r_state        <= ST_LEN_LO;
            r_words_loaded <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready     = w_in_session;
  assign o_busy         = w_in_session;
  assign o_done         = (r_state == ST_DONE);
  assign o_error        = (r_state == ST_ERR);
  assign o_imem_we      = w_word_valid;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = w_word;
  assign o_core_rst_n   = r_core_rst_n;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Sequencer that loads the program into the single-cycle core's instruction memory from a byte stream (UART/host bridge), then releases the core from reset. It holds the core in reset at power-up and during loading, assembles little-endian 32-bit words, writes them to consecutive word addresses, and flags length errors. It sits between the host byte interface and the core top, driving the core reset and the instruction-memory write port.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width
MAX_WORDS, 1024, maximum loadable words; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: begin a load session
rx_valid  input  1  byte available on rx_data
rx_data  input  8  incoming byte
rx_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address for the write
imem_wdata  output  32  assembled word
core_rst_n  output  1  core reset, active-low; 0 holds the core in reset
busy  output  1  session in progress (LEN_LO, LEN_HI, DATA)
done  output  1  load complete, core running
error  output  1  length error latched
words_loaded  output  ADDR_WIDTH+1  words written in current session

Behaviour:
- Byte handshake: byte consumed on a rising edge where rx_valid && rx_ready. rx_ready is a function of state only (1 in LEN_LO, LEN_HI, DATA; else 0), never of rx_valid.
- Session framing: 2-byte word count N, little-endian, then 4*N data bytes; each word's first byte goes to wdata[7:0], fourth to [31:24].
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- IDLE: start -> LEN_LO. LEN_LO: byte -> latch N[7:0], -> LEN_HI.
- LEN_HI: byte -> N[15:8]. Full N == 0 -> DONE; N > MAX_WORDS -> ERR; else -> DATA, byte counter = 0, word index = 0.
- DATA: each accepted byte shifts into assembler; on 4th byte of a word, next cycle imem_we = 1 for exactly one cycle with imem_addr = word index and full word on imem_wdata; word index and words_loaded increment on that same edge. On 4th byte of word N-1, state -> DONE on that edge, so the final imem_we pulse coincides with the first DONE cycle.
- DONE: done = 1; core_rst_n rises one cycle after entering DONE, so the last write completes before the core leaves reset. start in DONE -> LEN_LO, core_rst_n = 0 and done = 0 on the next edge, words_loaded cleared.
- ERR: error = 1, rx_ready = 0, core held in reset; only start (-> LEN_LO, error cleared) or rst exits.
- start is ignored in LEN_LO, LEN_HI, DATA; it does not abort a session.
- core_rst_n = 0 in every state except DONE (after the 1-cycle delay).
- Reset, asynchronous at any point including mid-session: state IDLE; rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, busy 0, done 0, error 0, words_loaded 0; partial word discarded.
- Gaps: rx_valid low for any number of cycles in LEN or DATA states stalls without timeout; the partial word is preserved.
- Word index never exceeds MAX_WORDS-1, guaranteed by the LEN_HI check; no address wrap.

Decomposition:
- Shared package/header: state encoding localparams (IDLE..ERR), LEN_BYTES = 2, BYTES_PER_WORD = 4.
- One sub-module, word_assembler: 2-bit byte counter plus 32-bit shift register. Inputs: byte, byte_valid, clear. Outputs: word, word_valid pulse.
- FSM, counters and reset generation stay in imem_boot_loader.

Test Plan:
- Power-up: rst high then low, no start -> core_rst_n = 0, rx_ready = 0, done = 0 indefinitely.
- Load N = 2: start; bytes 02 00 13 05 A0 00 93 05 B0 00 -> imem_we pulses at addr 0 data 0x00A00513 and addr 1 data 0x00B00593; done = 1 on the second pulse cycle, core_rst_n = 1 one cycle later, words_loaded = 2.
- N = 0: start; bytes 00 00 -> DONE, no imem_we, core_rst_n = 1 two cycles after the second byte is accepted.
- N = 1025 (01 04) with MAX_WORDS = 1024 -> error = 1, rx_ready = 0, core_rst_n = 0. A later start clears error and returns to LEN_LO.
- Stall plus mid-session reset: N = 1, send 2 data bytes, idle 10 cycles, then the remaining 2 -> word correct. Repeat, asserting rst after byte 3 -> all outputs at reset values, no imem_we.
- Reload: after DONE, start -> core_rst_n = 0 next cycle and start pulses during DATA are ignored; the new program overwrites from addr 0.
